// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage: FSM state
// encoding, the NOP word and PC helpers.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP        = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational redirect decision and target computation from the
// execute-stage branch/jump resolution. Jump takes priority over branch.
module next_pc_calc
  import instr_fetch_unit_pkg::*;
(
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic        ex_bne,
  input  logic        ex_zero,
  input  logic        ex_jump,
  input  logic [31:0] ex_pc_plus4,
  input  logic [31:0] ex_imm,
  input  logic [25:0] ex_jidx,
  output logic        redirect,
  output logic [31:0] target
);

  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign branch_taken  = ex_branch & (ex_zero ^ ex_bne);
  assign redirect      = ex_valid & (ex_jump | branch_taken);

  // Branch offset is in words; the add wraps silently mod 2^32.
  assign branch_target = ex_pc_plus4 + (ex_imm << 2);
  assign jump_target   = {ex_pc_plus4[31:28], ex_jidx, 2'b00};

  always_comb begin
    target = word_align(branch_target);
    if (ex_jump) begin
      target = jump_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack handshake, decode valid/ready port.
// Optional IF_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt counters.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
)
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [5:0]  id_opcode,
  output logic [31:0] id_pc_plus4,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic        ex_bne,
  input  logic        ex_zero,
  input  logic        ex_jump,
  input  logic [31:0] ex_pc_plus4,
  input  logic [31:0] ex_imm,
  input  logic [25:0] ex_jidx,
  output logic        fetch_err
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [31:0]      pc;
  logic [31:0]      pc_next;
  logic [31:0]      pend;
  logic [31:0]      pend_next;
  logic             capture;
  logic             redirect;
  logic [31:0]      target;
  logic             transfer;
  logic [CNT_W-1:0] wait_cnt;

  next_pc_calc u_next_pc_calc (
    .ex_valid    (ex_valid),
    .ex_branch   (ex_branch),
    .ex_bne      (ex_bne),
    .ex_zero     (ex_zero),
    .ex_jump     (ex_jump),
    .ex_pc_plus4 (ex_pc_plus4),
    .ex_imm      (ex_imm),
    .ex_jidx     (ex_jidx),
    .redirect    (redirect),
    .target      (target)
  );

  assign imem_req  = (state == REQ) || (state == DRAIN);
  assign imem_addr = pc;
  assign id_valid  = (state == HOLD) & ~redirect;
  assign transfer  = id_valid & id_ready;
  assign id_opcode = id_instr[31:26];

  // DRAIN keeps pc (the address in flight) untouched and parks the redirect in pend.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    pend_next  = pend;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        state_next = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_next = target;
          end else begin
            capture    = 1'b1;
            state_next = HOLD;
          end
        end else if (redirect) begin
          pend_next  = target;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          pc_next    = redirect ? target : pend;
          state_next = REQ;
        end else if (redirect) begin
          pend_next = target;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_next    = target;
          state_next = REQ;
        end else if (id_ready) begin
          pc_next    = pc_inc(pc);
          state_next = REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= word_align(RESET_PC);
      pend  <= word_align(RESET_PC);
    end else begin
      state <= state_next;
      pc    <= word_align(pc_next);
      pend  <= word_align(pend_next);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_instr    <= NOP;
      id_pc_plus4 <= 32'h0;
    end else if (capture) begin
      id_instr    <= imem_rdata;
      id_pc_plus4 <= pc_inc(pc);
    end
  end

  // Counter saturates so a long stall cannot wrap it; fetch_err is sticky until rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (!imem_req || imem_ack) begin
        wait_cnt <= '0;
      end else if (wait_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (imem_req && !imem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
        fetch_err <= 1'b1;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (transfer) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (imem_req && !imem_ack) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_transfer;
  assign unused_transfer = transfer;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a behavioural imem responds to requests,
// expected fetch addresses and decode transfers are queued and checked by a monitor.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [5:0]  id_opcode;
  logic [31:0] id_pc_plus4;
  logic        ex_valid;
  logic        ex_branch;
  logic        ex_bne;
  logic        ex_zero;
  logic        ex_jump;
  logic [31:0] ex_pc_plus4;
  logic [31:0] ex_imm;
  logic [25:0] ex_jidx;
  logic        fetch_err;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } xfer_t;

  int          errors = 0;
  int          checks = 0;
  int          cycle = 0;
  int          xfer_cnt = 0;
  int          xfer_cycle[$];
  logic [31:0] exp_addr_q[$];
  xfer_t       exp_xfer_q[$];
  int          ack_delay = 1;
  bit          ack_enable = 1'b1;
  bit          stray_ack = 1'b0;

  instr_fetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_opcode   (id_opcode),
    .id_pc_plus4 (id_pc_plus4),
    .ex_valid    (ex_valid),
    .ex_branch   (ex_branch),
    .ex_bne      (ex_bne),
    .ex_zero     (ex_zero),
    .ex_jump     (ex_jump),
    .ex_pc_plus4 (ex_pc_plus4),
    .ex_imm      (ex_imm),
    .ex_jidx     (ex_jidx),
    .fetch_err   (fetch_err)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Distinct word per address so a wrong fetch shows up in id_instr and id_opcode.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:2] ^ 6'h2A, a[27:2]};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (id_valid !== 1'b1 && n < 60);
    checks++;
    if (id_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s: id_valid=%0b after %0d cycles, required 1", name, id_valid, n);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic br, input logic bne, input logic z,
                                input logic j, input logic [31:0] pcp4, input logic [31:0] imm,
                                input logic [25:0] jidx);
    ex_valid    = v;
    ex_branch   = br;
    ex_bne      = bne;
    ex_zero     = z;
    ex_jump     = j;
    ex_pc_plus4 = pcp4;
    ex_imm      = imm;
    ex_jidx     = jidx;
  endtask

  task automatic push_xfer(input logic [31:0] addr, input logic [31:0] pcp4);
    xfer_t e;
    e.instr    = mem_word(addr);
    e.pc_plus4 = pcp4;
    exp_xfer_q.push_back(e);
  endtask

  // Behavioural instruction memory with a programmable wait count.
  initial begin
    int wcnt;
    wcnt       = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_ack || !imem_req) wcnt = 0;
      imem_ack = 1'b0;
      if (stray_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
      end else if (imem_req && ack_enable) begin
        if (wcnt >= ack_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Monitor: completed fetches and decode transfers are popped against the queues.
  initial begin
    xfer_t e;
    forever begin
      @(negedge clk);
      if (!rst && imem_req && imem_ack) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL fetch_addr: unexpected fetch at 0x%08h, none required", imem_addr);
        end else begin
          check_output("fetch_addr", imem_addr, exp_addr_q.pop_front());
        end
      end
      if (!rst && id_valid && id_ready) begin
        xfer_cnt++;
        xfer_cycle.push_back(cycle);
        if (exp_xfer_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL xfer: unexpected transfer pc_plus4=0x%08h, none required", id_pc_plus4);
        end else begin
          e = exp_xfer_q.pop_front();
          check_output("xfer_instr", id_instr, e.instr);
          check_output("xfer_opcode", {26'h0, id_opcode}, {26'h0, e.instr[31:26]});
          check_output("xfer_pc_plus4", id_pc_plus4, e.pc_plus4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    id_ready = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 26'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_imem_req", {31'h0, imem_req}, 32'h0);
    check_output("rst_imem_addr", imem_addr, 32'h0);
    check_output("rst_id_valid", {31'h0, id_valid}, 32'h0);
    check_output("rst_id_instr", id_instr, 32'h0);
    check_output("rst_id_opcode", {26'h0, id_opcode}, 32'h0);
    check_output("rst_id_pc_plus4", id_pc_plus4, 32'h0);
    check_output("rst_fetch_err", {31'h0, fetch_err}, 32'h0);

    // Sequential fetch with a one-wait imem and decode always ready.
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    exp_addr_q.push_back(32'hC);
    push_xfer(32'h0, 32'h4);
    push_xfer(32'h4, 32'h8);
    push_xfer(32'h8, 32'hC);
    tick();
    rst      = 1'b0;
    id_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (xfer_cnt >= 3) break;
    end
    id_ready = 1'b0;
    check_output("seq_xfer_count", xfer_cnt, 3);
    if (xfer_cycle.size() >= 3) begin
      check_output("throughput_1", xfer_cycle[1] - xfer_cycle[0], 3);
      check_output("throughput_2", xfer_cycle[2] - xfer_cycle[1], 3);
    end

    // Decode stalls: the held instruction must stay put with no new request.
    wait_valid("hold_0xc");
    for (int i = 0; i < 5; i++) begin
      check_output("stall_id_valid", {31'h0, id_valid}, 32'h1);
      check_output("stall_id_instr", id_instr, mem_word(32'hC));
      check_output("stall_no_req", {31'h0, imem_req}, 32'h0);
      @(negedge clk);
    end
    check_output("stall_pc_plus4", id_pc_plus4, 32'h10);

    // BEQ taken in HOLD squashes even with id_ready high.
    tick();
    exp_addr_q.push_back(32'h8);
    apply_stimulus(1, 1, 0, 1, 0, 32'h10, 32'hFFFF_FFFE, 26'h0);
    id_ready = 1'b1;
    @(negedge clk);
    check_output("beq_squash_valid", {31'h0, id_valid}, 32'h0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 26'h0);
    id_ready = 1'b0;
    check_output("beq_req", {31'h0, imem_req}, 32'h1);
    check_output("beq_target_addr", imem_addr, 32'h8);
    wait_valid("hold_after_beq");
    check_output("beq_hold_pc_plus4", id_pc_plus4, 32'hC);

    // Jump during an outstanding request: address held, data discarded.
    ack_delay = 3;
    push_xfer(32'h8, 32'hC);
    exp_addr_q.push_back(32'hC);
    exp_addr_q.push_back(32'h3000_0100);
    tick();
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    apply_stimulus(1, 0, 0, 0, 1, 32'h3000_0008, 32'h0, 26'h0000040);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 26'h0);
    check_output("drain_req", {31'h0, imem_req}, 32'h1);
    check_output("drain_addr_stable", imem_addr, 32'hC);
    wait_valid("hold_after_jump");
    check_output("jump_pc_plus4", id_pc_plus4, 32'h3000_0104);
    check_output("jump_instr", id_instr, mem_word(32'h3000_0100));

    // ack and BNE taken in the same REQ cycle.
    ack_delay = 0;
    push_xfer(32'h3000_0100, 32'h3000_0104);
    exp_addr_q.push_back(32'h3000_0104);
    exp_addr_q.push_back(32'h3000_0148);
    tick();
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    apply_stimulus(1, 1, 1, 0, 0, 32'h3000_0108, 32'h0000_0010, 26'h0);
    @(negedge clk);
    check_output("bne_ack_no_valid", {31'h0, id_valid}, 32'h0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 26'h0);
    check_output("bne_target_addr", imem_addr, 32'h3000_0148);
    @(negedge clk);
    check_output("bne_still_no_valid", {31'h0, id_valid}, 32'h0);
    wait_valid("hold_after_bne");
    check_output("bne_pc_plus4", id_pc_plus4, 32'h3000_014C);
`ifdef IF_PERF_CNT_EN
    check_output("perf_fetch_cnt", perf_fetch_cnt, 32'd5);
`endif

    // Jump to the top word, then sequential fetch wraps to 0.
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0);
    tick();
    apply_stimulus(1, 0, 0, 0, 1, 32'hF000_0000, 32'h0, 26'h3FF_FFFF);
    @(negedge clk);
    check_output("jump_hold_squash", {31'h0, id_valid}, 32'h0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 26'h0);
    wait_valid("hold_top_word");
    check_output("wrap_pc_plus4", id_pc_plus4, 32'h0);
    push_xfer(32'hFFFF_FFFC, 32'h0);
    tick();
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    wait_valid("hold_after_wrap");
    check_output("wrap_instr", id_instr, mem_word(32'h0));
    check_output("wrap_next_pc_plus4", id_pc_plus4, 32'h4);

    // Timeout: no ack for 16 request cycles sets the sticky error.
    ack_enable = 1'b0;
    push_xfer(32'h0, 32'h4);
    tick();
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 16) check_output("fetch_err_before_timeout", {31'h0, fetch_err}, 32'h0);
      if (k == 17) begin
        check_output("fetch_err_at_timeout", {31'h0, fetch_err}, 32'h1);
        check_output("timeout_req_continues", {31'h0, imem_req}, 32'h1);
        check_output("timeout_addr", imem_addr, 32'h4);
      end
    end
    exp_addr_q.push_back(32'h4);
    ack_enable = 1'b1;
    wait_valid("hold_after_late_ack");
    check_output("fetch_err_sticky", {31'h0, fetch_err}, 32'h1);
    check_output("late_ack_pc_plus4", id_pc_plus4, 32'h8);

    // Reset in the middle of a request, then a stray ack while IDLE.
    ack_enable = 1'b0;
    push_xfer(32'h4, 32'h8);
    tick();
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_output("midreq_rst_req", {31'h0, imem_req}, 32'h0);
    check_output("midreq_rst_fetch_err", {31'h0, fetch_err}, 32'h0);
    check_output("midreq_rst_addr", imem_addr, 32'h0);
    check_output("midreq_rst_pc_plus4", id_pc_plus4, 32'h0);
    ack_enable = 1'b1;
    ack_delay  = 1;
    @(negedge clk);
    stray_ack = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    stray_ack = 1'b0;
    check_output("idle_no_req", {31'h0, imem_req}, 32'h0);
    exp_addr_q.push_back(32'h0);
    wait_valid("hold_after_reset");
    check_output("stray_ack_ignored", id_instr, mem_word(32'h0));
    check_output("post_reset_pc_plus4", id_pc_plus4, 32'h4);

    @(negedge clk);
    check_output("addr_queue_drained", exp_addr_q.size(), 0);
    check_output("xfer_queue_drained", exp_xfer_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
